main_mem_responder: RTL and testbench

- Responder (memory side) of the main-memory valid/ready protocol driven by the load/store execution element.
- Accepts one word write request (in_* channel) or one word read request (out_* channel) at a time.
- Services requests from an internal single-port word memory with a fixed, parameterised latency.
- Returns completion as a one-cycle ready pulse, with read data on that same cycle.

---
 rtl/main_mem_responder_if.sv | 23 ++
 rtl/main_mem_responder.sv | 156 +++++++++++++++
 tb/tb_main_mem_responder.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_responder_if.sv
// Main-memory valid/ready bus between the load/store element (master) and memory (slave).
interface main_mem_responder_if;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_addr;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        range_err;

  modport master (
    output in_addr, in_data, in_valid, out_addr, out_valid,
    input  in_ready, out_data, out_ready, busy, range_err
  );

  modport slave (
    input  in_addr, in_data, in_valid, out_addr, out_valid,
    output in_ready, out_data, out_ready, busy, range_err
  );
endinterface

// File: rtl/main_mem_responder.sv
// Memory-side responder: serialises one write or read at a time against an internal
// word memory and answers each with a one-cycle ready pulse after a fixed latency.
module main_mem_responder #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  main_mem_responder_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitW,
    StWaitR,
    StRespW,
    StRespR
  } state_e;

  // Last WAIT count before the response state is entered.
  localparam logic [3:0] LatLast = 4'(LATENCY - 1);

  state_e      r_state;
  state_e      w_state_d;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_d;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_out_data;
  logic        r_range_err;
  logic [31:0] r_mem [2**ADDR_W];

  logic        w_accept_w;
  logic        w_accept_r;
  logic [31:0] w_cur_addr;
  logic [31:0] w_cur_data;
  logic        w_in_range;
  logic        w_enter_resp_w;
  logic        w_enter_resp_r;

  // Writes win when both valids are high; the read waits for a later IDLE edge.
  assign w_accept_w = (r_state == StIdle) && bus.in_valid;
  assign w_accept_r = (r_state == StIdle) && !bus.in_valid && bus.out_valid;

  // Address/data of the request being serviced; taken straight from the bus on the
  // acceptance edge so a LATENCY of 1 can commit on that same edge.
  always_comb begin
    w_cur_addr = r_addr;
    w_cur_data = r_data;
    if (w_accept_w) begin
      w_cur_addr = bus.in_addr;
      w_cur_data = bus.in_data;
    end else if (w_accept_r) begin
      w_cur_addr = bus.out_addr;
    end
  end

  assign w_in_range = (w_cur_addr[31:ADDR_W] == '0);

  // Next-state and latency counter.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept_w) begin
          if (LATENCY == 1) begin
            w_state_d = StRespW;
          end else begin
            w_state_d = StWaitW;
            w_cnt_d   = 4'd1;
          end
        end else if (w_accept_r) begin
          if (LATENCY == 1) begin
            w_state_d = StRespR;
          end else begin
            w_state_d = StWaitR;
            w_cnt_d   = 4'd1;
          end
        end
      end
      StWaitW: begin
        if (r_cnt >= LatLast) begin
          w_state_d = StRespW;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      StWaitR: begin
        if (r_cnt >= LatLast) begin
          w_state_d = StRespR;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 4'd1;
        end
      end
      StRespW, StRespR: begin
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  assign w_enter_resp_w = (w_state_d == StRespW) && (r_state != StRespW) && !reset;
  assign w_enter_resp_r = (w_state_d == StRespR) && (r_state != StRespR) && !reset;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Request capture, sticky range error and registered read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_out_data  <= '0;
      r_range_err <= 1'b0;
    end else begin
      if (w_accept_w || w_accept_r) begin
        r_addr <= w_cur_addr;
        r_data <= w_cur_data;
        if (!w_in_range) begin
          r_range_err <= 1'b1;
        end
      end
      if (w_enter_resp_r) begin
        r_out_data <= w_in_range ? r_mem[w_cur_addr[ADDR_W-1:0]] : '0;
      end
    end
  end

  // Memory commit; contents survive reset, out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (w_enter_resp_w && w_in_range) begin
      r_mem[w_cur_addr[ADDR_W-1:0]] <= w_cur_data;
    end
  end

  assign bus.in_ready  = (r_state == StRespW);
  assign bus.out_ready = (r_state == StRespR);
  assign bus.busy      = (r_state != StIdle);
  assign bus.out_data  = r_out_data;
  assign bus.range_err = r_range_err;

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder: three instances (LATENCY 2, 1, 5) share one
// stimulus driver, selected by 'sel'.
module tb_main_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          sel = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  logic [31:0] t_in_addr = '0;
  logic [31:0] t_in_data = '0;
  logic        t_in_valid = 1'b0;
  logic [31:0] t_out_addr = '0;
  logic        t_out_valid = 1'b0;

  logic        m_in_ready, m_out_ready, m_busy, m_range_err;
  logic [31:0] m_out_data;

  always #5 clk = ~clk;

  main_mem_responder_if b0 ();
  main_mem_responder_if b1 ();
  main_mem_responder_if b2 ();

  assign b0.in_addr   = t_in_addr;
  assign b0.in_data   = t_in_data;
  assign b0.out_addr  = t_out_addr;
  assign b0.in_valid  = t_in_valid && (sel == 0);
  assign b0.out_valid = t_out_valid && (sel == 0);
  assign b1.in_addr   = t_in_addr;
  assign b1.in_data   = t_in_data;
  assign b1.out_addr  = t_out_addr;
  assign b1.in_valid  = t_in_valid && (sel == 1);
  assign b1.out_valid = t_out_valid && (sel == 1);
  assign b2.in_addr   = t_in_addr;
  assign b2.in_data   = t_in_data;
  assign b2.out_addr  = t_out_addr;
  assign b2.in_valid  = t_in_valid && (sel == 2);
  assign b2.out_valid = t_out_valid && (sel == 2);

  main_mem_responder #(.ADDR_W(16), .LATENCY(2)) u_l2 (.clk(clk), .reset(reset), .bus(b0));
  main_mem_responder #(.ADDR_W(16), .LATENCY(1)) u_l1 (.clk(clk), .reset(reset), .bus(b1));
  main_mem_responder #(.ADDR_W(16), .LATENCY(5)) u_l5 (.clk(clk), .reset(reset), .bus(b2));

  always_comb begin
    m_in_ready  = b0.in_ready;
    m_out_ready = b0.out_ready;
    m_busy      = b0.busy;
    m_range_err = b0.range_err;
    m_out_data  = b0.out_data;
    if (sel == 1) begin
      m_in_ready  = b1.in_ready;
      m_out_ready = b1.out_ready;
      m_busy      = b1.busy;
      m_range_err = b1.range_err;
      m_out_data  = b1.out_data;
    end else if (sel == 2) begin
      m_in_ready  = b2.in_ready;
      m_out_ready = b2.out_ready;
      m_busy      = b2.busy;
      m_range_err = b2.range_err;
      m_out_data  = b2.out_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request with the initiator holding valid through the ready edge.
  // Entered and left just after an edge with the selected DUT idle.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     output logic [31:0] rdata, output int lat);
    logic extra;
    lat   = -1;
    rdata = '0;
    if (wr) begin
      t_in_addr  = addr;
      t_in_data  = data;
      t_in_valid = 1'b1;
    end else begin
      t_out_addr  = addr;
      t_out_valid = 1'b1;
    end
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      step();
      if (wr ? m_in_ready : m_out_ready) begin
        lat   = k;
        rdata = m_out_data;
      end
    end
    step();
    extra = wr ? m_in_ready : m_out_ready;
    chk("single_pulse", {31'b0, extra}, 32'h0);
    t_in_valid  = 1'b0;
    t_out_valid = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[14];
  logic [31:0] rd;
  logic [31:0] last_rd;
  int          lat;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0011, 32'hA5A5_0001, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0011, 32'h0,         32'hA5A5_0001, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0000, 32'h0000_1111, 32'h0,         1'b0};
    vecs[6]  = '{1'b1, 32'h0000_FFFF, 32'h7777_8888, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h0000_FFFF, 32'h0,         32'h7777_8888, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_1111, 1'b0};
    vecs[9]  = '{1'b0, 32'h0001_0000, 32'h0,         32'h0,         1'b1};
    vecs[10] = '{1'b1, 32'h0001_0000, 32'hBAD0_BAD0, 32'h0,         1'b1};
    vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_1111, 1'b1};
    vecs[12] = '{1'b0, 32'h8000_0010, 32'h0,         32'h0,         1'b1};
    vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b1};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      chk("rst_in_ready", {31'b0, m_in_ready}, 32'h0);
      chk("rst_out_ready", {31'b0, m_out_ready}, 32'h0);
      chk("rst_busy", {31'b0, m_busy}, 32'h0);
      chk("rst_range_err", {31'b0, m_range_err}, 32'h0);
      chk("rst_out_data", m_out_data, 32'h0);
    end
    sel = 0;
    step();

    // Table-driven transactions, LATENCY=2
    last_rd = '0;
    for (int i = 0; i < 14; i++) begin
      txn(vecs[i].wr, vecs[i].addr, vecs[i].data, rd, lat);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d_out_data_held", i), m_out_data, last_rd);
      end else begin
        chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
        last_rd = vecs[i].exp;
      end
      chk($sformatf("vec%0d_range_err", i), {31'b0, m_range_err}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d_idle", i), {31'b0, m_busy}, 32'h0);
    end

    // Simultaneous write and read: write first, read on the IDLE edge after
    begin
      int wk, rk, nw, nr;
      logic [31:0] sd;
      wk = -1; rk = -1; nw = 0; nr = 0; sd = '0;
      t_in_addr = 32'h20; t_in_data = 32'h1234_5678; t_out_addr = 32'h20;
      t_in_valid = 1'b1; t_out_valid = 1'b1;
      for (int k = 1; k <= 12; k++) begin
        step();
        if (wk > 0 && k == wk + 1) t_in_valid = 1'b0;
        if (rk > 0 && k == rk + 1) t_out_valid = 1'b0;
        if (m_in_ready) begin
          if (wk < 0) wk = k;
          nw++;
        end
        if (m_out_ready) begin
          if (rk < 0) begin
            rk = k;
            sd = m_out_data;
          end
          nr++;
        end
      end
      t_in_valid = 1'b0; t_out_valid = 1'b0;
      chk("simul_write_cycle", 32'(wk), 32'd2);
      chk("simul_read_cycle", 32'(rk), 32'd5);
      chk("simul_write_pulses", 32'(nw), 32'd1);
      chk("simul_read_pulses", 32'(nr), 32'd1);
      chk("simul_read_data", sd, 32'h1234_5678);
    end

    // No re-accept with valid held through the ready edge, LATENCY 1 and 5
    for (int s = 1; s < 3; s++) begin
      int np;
      logic [31:0] wd;
      sel = s;
      wd = 32'h0BAD_F000 + 32'(s);
      step();
      txn(1'b1, 32'h5, wd, rd, lat);
      chk($sformatf("sweep%0d_wr_latency", s), 32'(lat), (s == 1) ? 32'd1 : 32'd5);
      txn(1'b0, 32'h5, 32'h0, rd, lat);
      chk($sformatf("sweep%0d_rd_latency", s), 32'(lat), (s == 1) ? 32'd1 : 32'd5);
      chk($sformatf("sweep%0d_rd_data", s), rd, wd);
      chk($sformatf("sweep%0d_busy_after", s), {31'b0, m_busy}, 32'h0);
      np = 0;
      for (int k = 0; k < 8; k++) begin
        step();
        if (m_out_ready || m_in_ready || m_busy) np++;
      end
      chk($sformatf("sweep%0d_no_reaccept", s), 32'(np), 32'd0);
    end

    // Reset while a write sits in WAIT_W
    sel = 0;
    step();
    txn(1'b1, 32'h30, 32'h1111_2222, rd, lat);
    chk("rstmid_pre_err", {31'b0, m_range_err}, 32'h1);
    t_in_addr = 32'h30; t_in_data = 32'hCAFE_F00D; t_in_valid = 1'b1;
    step();
    chk("rstmid_in_wait", {31'b0, m_busy}, 32'h1);
    reset = 1'b1;
    t_in_valid = 1'b0;
    step();
    reset = 1'b0;
    begin
      int np;
      np = 0;
      chk("rstmid_busy", {31'b0, m_busy}, 32'h0);
      chk("rstmid_range_err", {31'b0, m_range_err}, 32'h0);
      for (int k = 0; k < 6; k++) begin
        if (m_in_ready) np++;
        step();
      end
      chk("rstmid_no_ready", 32'(np), 32'd0);
    end
    txn(1'b0, 32'h30, 32'h0, rd, lat);
    chk("rstmid_old_data", rd, 32'h1111_2222);
    chk("rstmid_err_after", {31'b0, m_range_err}, 32'h0);

    // Throughput: 8 back-to-back reads at LATENCY=1
    sel = 1;
    step();
    for (int i = 0; i < 8; i++) begin
      txn(1'b1, 32'h40 + 32'(i), 32'h1000_0000 + 32'(i) * 32'h111, rd, lat);
    end
    begin
      int idx, prev, np;
      logic adv;
      idx = 0; prev = -1; np = 0; adv = 1'b0;
      t_out_addr = 32'h40; t_out_valid = 1'b1;
      for (int k = 1; k <= 24; k++) begin
        step();
        if (adv) begin
          adv = 1'b0;
          if (idx < 8) t_out_addr = 32'h40 + 32'(idx);
          else t_out_valid = 1'b0;
        end
        if (m_out_ready) begin
          np++;
          if (idx < 8) begin
            chk($sformatf("tput%0d_data", idx), m_out_data, 32'h1000_0000 + 32'(idx) * 32'h111);
            if (prev > 0) chk($sformatf("tput%0d_spacing", idx), 32'(k - prev), 32'd2);
          end
          prev = k;
          idx++;
          adv = 1'b1;
        end
      end
      t_out_valid = 1'b0;
      chk("tput_pulse_count", 32'(np), 32'd8);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
